// File: rtl/ro_meter_pkg.sv
// Shared types and defaults for the ring-oscillator frequency meter.
package ro_meter_pkg;

  localparam int unsigned CntWDefault      = 16;
  localparam int unsigned GateCycDefault   = 1024;
  localparam int unsigned SettleCycDefault = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StMeasure,
    StDone
  } ro_meter_state_t;

  // Timer holds at most max(gate, settle) - 1, so clog2(max) bits suffice (min 1).
  function automatic int unsigned timer_width(input int unsigned gate, input int unsigned settle);
    int unsigned mx;
    mx = (gate > settle) ? gate : settle;
    return (mx > 1) ? $clog2(mx) : 1;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer for the asynchronous oscillator output, plus a history
// flop used to detect rising edges in the clk domain.
module ro_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  // Synchronizer chain and edge-history flop; rst_n is active-high.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, waits SETTLE_CYC
// cycles, then counts synchronized rising edges of ro_in over GATE_CYC cycles
// into a saturating counter.
// Optional build macro RO_FREQ_METER_ACCUM_EN: count/overflow survive start and
// accumulate across windows, clearing only on reset.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int unsigned CNT_W      = CntWDefault,
  parameter int unsigned GATE_CYC   = GateCycDefault,
  parameter int unsigned SETTLE_CYC = SettleCycDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_in,
  output logic             ro_activate,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned TimerW = timer_width(GATE_CYC, SETTLE_CYC);
  localparam logic [TimerW-1:0] SettleLoad = TimerW'(SETTLE_CYC - 1);
  localparam logic [TimerW-1:0] GateLoad   = TimerW'(GATE_CYC - 1);

  ro_meter_state_t   state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              act_q, act_d;
  logic              rise;

  ro_sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ro_in),
    .rise  (rise)
  );

  // Next-state logic: FSM sequencing, window timer and saturating edge counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          timer_d = SettleLoad;
`ifdef RO_FREQ_METER_ACCUM_EN
          // Accumulating build: keep previous totals.
`else
          count_d = '0;
          ovf_d   = 1'b0;
`endif
        end
      end
      StSettle: begin
        if (timer_q == '0) begin
          state_d = StMeasure;
          timer_d = GateLoad;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StMeasure: begin
        // An edge in the final window cycle is still counted.
        if (rise) begin
          if (count_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        if (timer_q == '0) begin
          state_d = StDone;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    act_d = (state_d == StSettle) || (state_d == StMeasure);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      act_q   <= act_d;
    end
  end

  assign ro_activate = act_q;
  assign busy        = (state_q == StSettle) || (state_q == StMeasure);
  assign done        = (state_q == StDone);
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter. Two instances share stimulus: a wide
// counter and a 4-bit counter that saturates. Expected counts come from the
// recorded rising-edge times of ro_in and the measurement window boundaries.
module tb_ro_freq_meter;

  localparam int unsigned G  = 64;
  localparam int unsigned S  = 8;
  localparam int unsigned W  = 16;
  localparam int unsigned WS = 4;
  localparam int MaxA = (1 << W) - 1;
  localparam int MaxB = (1 << WS) - 1;

  logic clk = 1'b0;
  logic rst_n, start, ro_in;
  logic act_a, busy_a, done_a, ovf_a;
  logic act_b, busy_b, done_b, ovf_b;
  logic [W-1:0]  cnt_a;
  logic [WS-1:0] cnt_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rises[$];
  int mode = 0;
  int per = 8;
  int phase = 0;
  bit stat_val = 1'b0;
  int acc_a = 0;
  int acc_b = 0;

  ro_freq_meter #(.CNT_W(W), .GATE_CYC(G), .SETTLE_CYC(S)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ro_in       (ro_in),
    .ro_activate (act_a),
    .busy        (busy_a),
    .done        (done_a),
    .count       (cnt_a),
    .overflow    (ovf_a)
  );

  ro_freq_meter #(.CNT_W(WS), .GATE_CYC(G), .SETTLE_CYC(S)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ro_in       (ro_in),
    .ro_activate (act_b),
    .busy        (busy_b),
    .done        (done_b),
    .count       (cnt_b),
    .overflow    (ovf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then drive the next ro_in value and log its rising edges.
  task automatic tick();
    logic v;
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       v = stat_val;
      1:       v = (((cyc + phase) % per) < (per / 2));
      default: v = 1'($urandom_range(0, 1));
    endcase
    if (v && !ro_in) rises.push_back(cyc);
    ro_in = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_done_a", 32'(done_a), 0);
      chk("idle_busy_a", 32'(busy_a), 0);
      chk("idle_done_b", 32'(done_b), 0);
    end
  endtask

  // One measurement; optionally re-pulse start in SETTLE, MEASURE and DONE.
  task automatic measure(input bit extra);
    int t0;
    int n;
    int ea, eb;
    t0 = cyc;
    start = 1'b1;
`ifndef RO_FREQ_METER_ACCUM_EN
    acc_a = 0;
    acc_b = 0;
`endif
    for (int k = 1; k <= int'(S + G + 1); k++) begin
      tick();
      start = 1'b0;
      if (extra && (k == 3 || k == int'(S) + 10 || k == int'(S + G + 1))) start = 1'b1;
      if (k <= int'(S + G)) begin
        chk("win_busy", 32'(busy_a), 1);
        chk("win_act", 32'(act_a), 1);
        chk("win_done", 32'(done_a), 0);
        chk("win_act_b", 32'(act_b), 1);
      end else begin
        // Edge at cycle r increments the counter at the end of cycle r+2.
        n = 0;
        foreach (rises[i]) begin
          if (rises[i] + 2 >= t0 + int'(S) + 1 && rises[i] + 2 <= t0 + int'(S + G)) n++;
        end
        acc_a += n;
        acc_b += n;
        ea = (acc_a > MaxA) ? MaxA : acc_a;
        eb = (acc_b > MaxB) ? MaxB : acc_b;
        chk("done_a", 32'(done_a), 1);
        chk("done_b", 32'(done_b), 1);
        chk("done_busy", 32'(busy_a), 0);
        chk("done_act", 32'(act_a), 0);
        chk("count_a", 32'(cnt_a), ea);
        chk("ovf_a", 32'(ovf_a), (acc_a > MaxA) ? 1 : 0);
        chk("count_b", 32'(cnt_b), eb);
        chk("ovf_b", 32'(ovf_b), (acc_b > MaxB) ? 1 : 0);
      end
    end
    tick();
    start = 1'b0;
    chk("after_busy", 32'(busy_a), 0);
    chk("after_done", 32'(done_a), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_count_a", 32'(cnt_a), (acc_a > MaxA) ? MaxA : acc_a);
      chk("hold_done", 32'(done_a), 0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    ro_in = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_act", 32'(act_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    rst_n = 1'b0;
    idle(2);

    // Period-8 square wave, two consecutive windows.
    mode = 1;
    per = 8;
    phase = int'($urandom_range(0, 7));
    idle(4);
    measure(1'b0);
    measure(1'b0);

    // Static low, then static high.
    mode = 0;
    stat_val = 1'b0;
    idle(5);
    measure(1'b0);
    stat_val = 1'b1;
    idle(5);
    measure(1'b0);

    // Random bit stream.
    mode = 2;
    measure(1'b0);

    // Start interlock with a random period.
    mode = 1;
    per = int'($urandom_range(4, 12));
    phase = int'($urandom_range(0, 11));
    idle(3);
    measure(1'b1);

    // Saturation of the 4-bit counter (about 21 edges).
    per = 3;
    measure(1'b0);

    // Reset mid-MEASURE.
    per = 8;
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      start = 1'b0;
    end
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    acc_a = 0;
    acc_b = 0;
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_act", 32'(act_a), 0);
    chk("midrst_done", 32'(done_a), 0);
    chk("midrst_count", 32'(cnt_a), 0);
    chk("midrst_ovf_b", 32'(ovf_b), 0);
    idle(10);
    measure(1'b0);

    // A few random periods.
    for (int j = 0; j < 3; j++) begin
      per = int'($urandom_range(2, 16));
      phase = int'($urandom_range(0, 15));
      idle(int'($urandom_range(1, 6)));
      measure(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Measurement front end for the on-chip ring oscillator. It asserts the oscillator's enable, waits a settle interval, and then counts rising edges of the oscillator output over a fixed gate window of system clocks. The result is held in a saturating counter that the host reads. It sits between the host/control logic and the `ro` instance: its `ro_activate` output drives the oscillator enable, and the oscillator output returns on `ro_in`.

## Interface
Parameters:
- `CNT_W`, 16: width of the edge counter and of `count`.
- `GATE_CYC`, 1024: length of the measurement window in `clk` cycles; must be ≥ 1.
- `SETTLE_CYC`, 8: cycles `ro_activate` is held high before counting starts; must be ≥ 4 (oscillator enable register plus synchronizer fill).

Ports:
- `clk`  in  1: single system clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-high (despite the name).
- `start`  in  1: request a measurement; sampled only in IDLE.
- `ro_in`  in  1: oscillator output, asynchronous to `clk`.
- `ro_activate`  out  1: registered enable to the oscillator.
- `busy`  out  1: high in SETTLE and MEASURE.
- `done`  out  1: one-cycle pulse when `count` becomes valid.
- `count`  out  CNT_W: rising edges counted in the last window; held until the next `start`.
- `overflow`  out  1: sticky; set when the counter saturated during the window.

## Operation
- `ro_in` passes through a 2-flop synchronizer, followed by a third flop for edge history. A rising edge is `s2 & ~s3`.
- Frequency resolution is valid only for f_ro < f_clk/2. Faster oscillators alias; this is accepted and documented.
- FSM states are IDLE, SETTLE, MEASURE and DONE:
  - IDLE: on `start`=1, go to SETTLE; clear `count` and `overflow`; load the timer with SETTLE_CYC-1.
  - SETTLE: timer decrements. At 0, go to MEASURE and load the timer with GATE_CYC-1.
  - MEASURE: each detected rising edge increments `count`. At all-ones, `count` holds and `overflow` is set. At timer 0, go to DONE. An edge detected in the final MEASURE cycle is counted.
  - DONE: `done`=1 for this cycle only, then go to IDLE.
- `ro_activate` is 1 in SETTLE and MEASURE, and 0 in IDLE and DONE.
- `start` in any state other than IDLE is ignored; it is not queued.
- Edges seen in SETTLE, DONE or IDLE are never counted.
- Timer width is clog2(max(GATE_CYC,SETTLE_CYC)), with a minimum of 1.

## Timing
- Reset values: state IDLE, `ro_activate`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0, synchronizer flops 0.
- `start` is high at cycle 0 in IDLE:
  - Cycles 1..SETTLE_CYC: SETTLE.
  - Cycles SETTLE_CYC+1..SETTLE_CYC+GATE_CYC: MEASURE.
  - Cycle SETTLE_CYC+GATE_CYC+1: DONE. `done`=1, `count` is final, `ro_activate`=0.
- Start-to-done latency is 1+SETTLE_CYC+GATE_CYC cycles.
- Edge-to-count latency is 3 cycles (synchronizer plus history plus counter register).
- Reset asserted mid-operation returns to IDLE on the next edge with all outputs at reset values. No `done` pulse is issued.

## Configuration
- `RO_FREQ_METER_ACCUM_EN` defined: `count` and `overflow` are not cleared on `start`, so successive windows accumulate. They clear only on reset. Saturation still applies.
- Not defined: `count` and `overflow` are cleared on every accepted `start`.

## Structure
- Package `ro_meter_pkg` holds:
  - The state enum typedef `ro_meter_state_t` (IDLE, SETTLE, MEASURE, DONE).
  - Default constants for CNT_W, GATE_CYC and SETTLE_CYC.
- One sub-module, `ro_sync_edge`: the 2-flop synchronizer plus history flop. It has inputs `clk`, `rst_n`, `d` and output `rise`.
- The FSM, timer and counter live in `ro_freq_meter`.

## Test plan
- Basic measurement:
  - Stimulus: GATE_CYC=64, SETTLE_CYC=8; `ro_in` driven synchronously with period 8 clk, rising edges every 8 cycles; pulse `start`.
  - Required: `done` at cycle 73; `count`=8 (±1 for phase); `overflow`=0; `ro_activate` high for cycles 1..72.
- Static input:
  - Stimulus: `ro_in` held at 0, then at 1.
  - Required: `count`=0 in both cases; `done` still pulses at cycle 73.
- Saturation:
  - Stimulus: CNT_W=4, `ro_in` period 4, GATE_CYC=64 (16 edges).
  - Required: `count`=15, `overflow`=1.
- Busy/start interlock:
  - Stimulus: `start` re-pulsed during SETTLE, MEASURE and DONE.
  - Required: ignored; exactly one `done`; `count` unchanged by the extra pulses.
- Reset mid-MEASURE:
  - Stimulus: assert `rst_n` at cycle 30.
  - Required: at cycle 31, IDLE, `ro_activate`=0, `count`=0, no `done`; a following `start` measures normally.
- Accumulation, with `RO_FREQ_METER_ACCUM_EN`:
  - Stimulus: two back-to-back measurements of the period-8 stimulus.
  - Required: `count`=16 after the second `done`; without the macro, `count`=8.
